// File: rtl/hub75_scan_timer.sv
// hub75_scan_timer: HUB75 row scan sequencer (shift, blank, latch, show) with linear PWM or BCM.
module hub75_scan_timer #(
   parameter  int COLS         = 64,
   parameter  int SCAN_ROWS    = 32,
   parameter  int PWM_BITS     = 5,
   parameter  int BLANK_CYCLES = 2,
   parameter  int BASE_ON      = 1,
   localparam int CW           = $clog2(COLS),
   localparam int RW           = $clog2(SCAN_ROWS),
   localparam int PW           = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                bcm_mode,
   output logic [CW-1:0]       col,
   output logic                shift_valid,
   output logic [RW-1:0]       scan_row,
   output logic [RW:0]         row_top,
   output logic [RW:0]         row_bottom,
   output logic [PWM_BITS-1:0] pwm_level,
   output logic [PW-1:0]       bit_plane,
   output logic [RW-1:0]       addr_out,
   output logic                lat,
   output logic                oe_n,
   output logic                frame_start
);
   localparam int MAX_ON = BASE_ON << (PWM_BITS - 1);
   localparam int OW     = $clog2(((MAX_ON > BLANK_CYCLES) ? MAX_ON : BLANK_CYCLES) + 1);

   typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, SHOW} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [OW-1:0]         cnt_q, cnt_d, on_len;
   logic [RW-1:0]         row_q, row_d, addr_q, addr_d;
   logic [PWM_BITS-1:0]   lvl_q, lvl_d;
   logic [PW-1:0]         plane_q, plane_d;
   logic                  mode_q, mode_d;
   logic                  sv_q, sv_d, lat_q, lat_d, oe_n_q, oe_n_d, fs_q, fs_d;
   logic                  start, bnd;

   // BCM doubles the on-time per plane; linear mode shows every level for the base weight
   assign on_len = mode_q ? (OW'(BASE_ON) << plane_q) : OW'(BASE_ON);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      lvl_d   = lvl_q;
      plane_d = plane_q;
      addr_d  = addr_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE:  state_d = en ? SHIFT : IDLE;
         SHIFT: begin
            col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
            state_d = (col_q == CW'(COLS - 1)) ? BLANK : SHIFT;
         end
         BLANK: begin
            cnt_d   = (cnt_q == OW'(BLANK_CYCLES - 1)) ? '0 : cnt_q + OW'(1);
            state_d = (cnt_q == OW'(BLANK_CYCLES - 1)) ? LATCH : BLANK;
         end
         LATCH: begin
            addr_d  = row_q;
            state_d = SHOW;
         end
         SHOW: begin
            cnt_d = cnt_q + OW'(1);
            if (cnt_q == on_len - OW'(1)) begin
               cnt_d   = '0;
               row_d   = row_q + RW'(1);
               state_d = en ? SHIFT : IDLE;
               if (row_q == RW'(SCAN_ROWS - 1)) begin
                  plane_d = !mode_q ? plane_q : (plane_q == PW'(PWM_BITS - 1)) ? '0 : plane_q + PW'(1);
                  lvl_d   = mode_q ? lvl_q : lvl_q + PWM_BITS'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      bnd    = (row_d == '0) && (lvl_d == '0) && (plane_d == '0);
      start  = (state_d == SHIFT) && (state_q != SHIFT);
      mode_d = (start && bnd) ? bcm_mode : mode_d;
      sv_d   = state_d == SHIFT;
      lat_d  = state_d == LATCH;
      oe_n_d = state_d != SHOW;
      fs_d   = start && bnd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         lvl_q   <= '0;
         plane_q <= '0;
         addr_q  <= '0;
         mode_q  <= 1'b0;
         sv_q    <= 1'b0;
         lat_q   <= 1'b0;
         oe_n_q  <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         lvl_q   <= lvl_d;
         plane_q <= plane_d;
         addr_q  <= addr_d;
         mode_q  <= mode_d;
         sv_q    <= sv_d;
         lat_q   <= lat_d;
         oe_n_q  <= oe_n_d;
         fs_q    <= fs_d;
      end
   end

   assign col         = col_q;
   assign shift_valid = sv_q;
   assign scan_row    = row_q;
   assign row_top     = {1'b0, row_q};
   assign row_bottom  = {1'b1, row_q};
   assign pwm_level   = lvl_q;
   assign bit_plane   = plane_q;
   assign addr_out    = addr_q;
   assign lat         = lat_q;
   assign oe_n        = oe_n_q;
   assign frame_start = fs_q;
endmodule
